uart_tx_tick: RTL and testbench



---
 rtl/uart_tx_tick_if.sv | 31 +++
 rtl/uart_tx_tick.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_tick.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_tick_if.sv
// Handshake and line signals of the tick-driven UART transmitter.
// The producer side (master) supplies the bit-period tick, the start request
// and the data word; the transmitter side (slave) returns the line and status.
interface uart_tx_tick_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_serial;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output baud_tick,
        output tx_start,
        output tx_data,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  baud_tick,
        input  tx_start,
        input  tx_data,
        output tx_serial,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_tick.sv
// Asynchronous serial transmitter paced by an external one-clock baud tick.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, stop bit(s).
// An ALIGN state waits for the first tick after acceptance so that the start
// bit always lasts one full tick period.
module uart_tx_tick #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_tick_if.slave  tx_if
);

    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic             PAR_EN    = (PARITY_EN != 0) ? 1'b1 : 1'b0;
    localparam logic             PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_e;

    state_e               state_q,  state_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 par_q,    par_d;
    logic                 stop_q,   stop_d;
    logic                 serial_q, serial_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    // Parity of a data word; odd selects the inverted (odd) sense.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word,
                                       input logic                 odd);
        return (^word) ^ odd;
    endfunction

    // Next-state and registered-output logic of the frame sequencer.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        stop_d   = stop_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_if.tx_start && !busy_q) begin
                    state_d = ST_ALIGN;
                    shift_d = tx_if.tx_data;
                    par_d   = parity_of(tx_if.tx_data, PAR_ODD);
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ALIGN: begin
                serial_d = 1'b1;
                if (tx_if.baud_tick) begin
                    state_d  = ST_START;
                    serial_d = 1'b0;
                end else begin
                    state_d = ST_ALIGN;
                end
            end

            ST_START: begin
                if (tx_if.baud_tick) begin
                    state_d  = ST_DATA;
                    serial_d = shift_q[0];
                    shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
                    cnt_d    = CNT_W'(1);
                end else begin
                    state_d = ST_START;
                end
            end

            ST_DATA: begin
                if (tx_if.baud_tick) begin
                    if (cnt_q == LAST_BIT) begin
                        if (PAR_EN) begin
                            state_d  = ST_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = ST_STOP;
                            serial_d = 1'b1;
                            stop_d   = 1'b0;
                        end
                    end else begin
                        serial_d = shift_q[0];
                        shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_PARITY: begin
                if (tx_if.baud_tick) begin
                    state_d  = ST_STOP;
                    serial_d = 1'b1;
                    stop_d   = 1'b0;
                end else begin
                    state_d = ST_PARITY;
                end
            end

            ST_STOP: begin
                serial_d = 1'b1;
                if (tx_if.baud_tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any frame and idles the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_if.tx_serial = serial_q;
    assign tx_if.tx_busy   = busy_q;
    assign tx_if.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: four instances (default 8N1, 8E1, 8O1,
// 7N2) share tick and start; each carries its own hand-written expected line.
module tb_uart_tx_tick;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic [7:0] data0, data1, data2;
    logic [6:0] data3;

    int n_checks = 0;
    int n_errors = 0;

    // Expected line after tick k of the current frame, bit k of exp_ser[d].
    logic [11:0] exp_ser [4];
    int          base_g  [4];
    int          dlen    [4];

    logic ser_w  [4];
    logic busy_w [4];
    logic done_w [4];

    uart_tx_tick_if #(.DATA_BITS(8)) if0 ();
    uart_tx_tick_if #(.DATA_BITS(8)) if1 ();
    uart_tx_tick_if #(.DATA_BITS(8)) if2 ();
    uart_tx_tick_if #(.DATA_BITS(7)) if3 ();

    assign if0.baud_tick = tick;  assign if0.tx_start = start;  assign if0.tx_data = data0;
    assign if1.baud_tick = tick;  assign if1.tx_start = start;  assign if1.tx_data = data1;
    assign if2.baud_tick = tick;  assign if2.tx_start = start;  assign if2.tx_data = data2;
    assign if3.baud_tick = tick;  assign if3.tx_start = start;  assign if3.tx_data = data3;

    assign ser_w[0] = if0.tx_serial;  assign busy_w[0] = if0.tx_busy;  assign done_w[0] = if0.tx_done;
    assign ser_w[1] = if1.tx_serial;  assign busy_w[1] = if1.tx_busy;  assign done_w[1] = if1.tx_done;
    assign ser_w[2] = if2.tx_serial;  assign busy_w[2] = if2.tx_busy;  assign done_w[2] = if2.tx_done;
    assign ser_w[3] = if3.tx_serial;  assign busy_w[3] = if3.tx_busy;  assign done_w[3] = if3.tx_done;

    uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
        dut0 (.clk(clk), .reset(reset), .tx_if(if0));
    uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0))
        dut1 (.clk(clk), .reset(reset), .tx_if(if1));
    uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
        dut2 (.clk(clk), .reset(reset), .tx_if(if2));
    uart_tx_tick #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0))
        dut3 (.clk(clk), .reset(reset), .tx_if(if3));

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic line_at(input int d, input int k);
        if (k < 0 || k > 11) return 1'b1;
        return exp_ser[d][k];
    endfunction

    task automatic set_frame(input int d, input logic [11:0] e, input int dl, input int b);
        exp_ser[d] = e;
        dlen[d]    = dl;
        base_g[d]  = b;
    endtask

    task automatic clk_step(input logic tk);
        tick = tk;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic check_idle_all(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s ser d%0d", tag, d), ser_w[d], 1'b1);
            chk($sformatf("%s busy d%0d", tag, d), busy_w[d], 1'b0);
            chk($sformatf("%s done d%0d", tag, d), done_w[d], 1'b0);
        end
    endtask

    // One tick period of four clocks; optional start pulse in the first clock,
    // checks one clock into the period and right after the tick edge.
    task automatic tick_period(input logic pulse, input int g);
        int k;
        start = pulse;
        clk_step(1'b0);
        start = 1'b0;
        if (pulse) begin
            data0 = ~data0;
            data1 = ~data1;
            data2 = ~data2;
            data3 = ~data3;
        end
        for (int d = 0; d < 4; d++) begin
            k = g - 1 - base_g[d];
            chk($sformatf("mid ser d%0d g%0d", d, g), ser_w[d], line_at(d, k));
            chk($sformatf("mid busy d%0d g%0d", d, g), busy_w[d],
                (base_g[d] == g) || (k >= 0 && k < dlen[d]));
            chk($sformatf("mid done d%0d g%0d", d, g), done_w[d], 1'b0);
        end
        clk_step(1'b0);
        clk_step(1'b0);
        clk_step(1'b1);
        for (int d = 0; d < 4; d++) begin
            k = g - base_g[d];
            chk($sformatf("ser d%0d g%0d", d, g), ser_w[d], line_at(d, k));
            chk($sformatf("busy d%0d g%0d", d, g), busy_w[d], (k >= 0 && k < dlen[d]));
            chk($sformatf("done d%0d g%0d", d, g), done_w[d], (k == dlen[d]));
        end
    endtask

    // Main stimulus sequence.
    initial begin
        logic pulse;
        reset = 1'b1;
        tick  = 1'b0;
        start = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        data2 = 8'h00;
        data3 = 7'h00;
        for (int d = 0; d < 4; d++) begin
            set_frame(d, 12'hFFF, 0, 1000);
        end

        #1 reset = 1'b0;
        #1 check_idle_all("rst_async");
        clk_step(1'b0);
        clk_step(1'b1);
        check_idle_all("rst_hold");
        reset = 1'b1;
        clk_step(1'b1);
        clk_step(1'b0);
        check_idle_all("rst_release");

        // Frame A: 0xA5 / 0xA5 even / 0xA5 odd / 7-bit 0x55 with two stops.
        data0 = 8'hA5;
        data1 = 8'hA5;
        data2 = 8'hA5;
        data3 = 7'h55;
        set_frame(0, {1'b1, 1'b1, 1'b1, 8'hA5, 1'b0}, 10, 0);
        set_frame(1, {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0);
        set_frame(2, {1'b1, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 0);
        set_frame(3, {1'b1, 1'b1, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 0);

        // Acceptance with a coincident tick: the tick must not start the frame.
        start = 1'b1;
        clk_step(1'b1);
        start = 1'b0;
        data0 = ~data0;
        data1 = ~data1;
        data2 = ~data2;
        data3 = ~data3;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("acc busy d%0d", d), busy_w[d], 1'b1);
            chk($sformatf("acc ser d%0d", d), ser_w[d], 1'b1);
            chk($sformatf("acc done d%0d", d), done_w[d], 1'b0);
        end

        for (int g = 0; g < 41; g++) begin
            pulse = 1'b0;
            if (g == 4) begin
                // Start while every instance is busy: must be ignored.
                data0 = 8'h00;
                data1 = 8'hFF;
                data2 = 8'h00;
                data3 = 7'h00;
                pulse = 1'b1;
            end
            if (g == 11) begin
                // Start held in the tx_done cycle of the 10-tick frames.
                data0 = 8'h3C;
                data3 = 7'h2A;
                set_frame(0, {1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 10, 11);
                set_frame(3, {1'b1, 1'b1, 1'b1, 1'b1, 7'h2A, 1'b0}, 10, 11);
                pulse = 1'b1;
            end
            if (g == 22) begin
                data0 = 8'h80;
                data1 = 8'h07;
                data2 = 8'h07;
                data3 = 7'h7F;
                set_frame(0, {1'b1, 1'b1, 1'b1, 8'h80, 1'b0}, 10, 22);
                set_frame(1, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 22);
                set_frame(2, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 22);
                set_frame(3, {1'b1, 1'b1, 1'b1, 1'b1, 7'h7F, 1'b0}, 10, 22);
                pulse = 1'b1;
            end
            if (g == 34) begin
                data0 = 8'h00;
                data1 = 8'h00;
                data2 = 8'h00;
                data3 = 7'h00;
                set_frame(0, {1'b1, 1'b1, 1'b1, 8'h00, 1'b0}, 10, 34);
                set_frame(1, {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}, 11, 34);
                set_frame(2, {1'b1, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 34);
                set_frame(3, {1'b1, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0}, 10, 34);
                pulse = 1'b1;
            end
            if (g == 38) begin
                // Reset in the middle of the data bits, off the clock edge.
                clk_step(1'b0);
                #2 reset = 1'b0;
                #1 check_idle_all("rst_mid");
                clk_step(1'b1);
                check_idle_all("rst_mid_hold");
                reset = 1'b1;
                clk_step(1'b0);
                check_idle_all("rst_mid_release");
                for (int d = 0; d < 4; d++) begin
                    set_frame(d, 12'hFFF, 0, 1000);
                end
            end
            tick_period(pulse, g);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
